// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame builder for the joystick SPI responder.
// Pure declarations; no clocked logic here.
package jstk_pkg;

  localparam int          JSTK_FRAME_BITS = 40;
  localparam logic [5:0]  JSTK_CMD_PREFIX = 6'b100000;

  localparam int BYTE_X_LO = 0;
  localparam int BYTE_X_HI = 1;
  localparam int BYTE_Y_LO = 2;
  localparam int BYTE_Y_HI = 3;
  localparam int BYTE_BTN  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } jstk_state_e;

  // Byte BYTE_X_LO goes out first, so it lands in the top bits of the shift register.
  function automatic logic [JSTK_FRAME_BITS-1:0] jstk_build_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 5'b0, btn};
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer with edge detect: level, rise and fall are valid SYNC_STAGES clk after the pin.
// No backpressure; edges are single-clk pulses.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to 0 so a chip select held low across reset release never looks like a fresh fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= din_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/jstk_responder.sv
// SPI mode-0 responder emulating the 5-byte joystick: shifts X/Y/buttons out on MISO, decodes the LED command byte.
// Acts SYNC_STAGES+1 clk after each pin edge; the master owns timing, so there is no backpressure.
module jstk_responder
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [2:0] buttons,
  output logic [1:0] led_cmd,
  output logic       cmd_valid,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [5:0] LAST_BIT = 6'(FRAME_BYTES * 8);

  logic ss_lvl,   ss_rise,   ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst_n(rst), .din_i(SS),
    .level_o(ss_lvl), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst), .din_i(SCLK),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst), .din_i(MOSI),
    .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  assign sync_unused = ^{ss_lvl, sclk_lvl, mosi_rise, mosi_fall};

  jstk_state_e                state_q;
  logic [JSTK_FRAME_BITS-1:0] tx_q;
  logic [JSTK_FRAME_BITS-1:0] frame_d;
  logic [7:0]                 rx_q;
  logic [7:0]                 rx_d;
  logic [5:0]                 bit_cnt_q;
  logic                       miso_q;
  logic [1:0]                 led_cmd_q;
  logic                       cmd_valid_q;
  logic                       frame_done_q;
  logic                       busy_q;

  assign frame_d = jstk_build_frame(x_pos, y_pos, buttons);
  assign rx_d    = {rx_q[6:0], mosi_lvl};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= '0;
      miso_q       <= 1'b0;
      led_cmd_q    <= 2'b00;
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          busy_q <= 1'b0;
          if (ss_fall) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ss_rise) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end else begin
            tx_q      <= frame_d;
            miso_q    <= frame_d[JSTK_FRAME_BITS-1];
            bit_cnt_q <= '0;
            rx_q      <= '0;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ss_rise) begin
            // Abort: any LED command already latched this frame is kept.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            miso_q  <= 1'b0;
          end else if (bit_cnt_q == LAST_BIT) begin
            state_q <= ST_DONE;
            miso_q  <= 1'b0;
          end else begin
            if (sclk_rise) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_q + 6'd1;
              if (bit_cnt_q == 6'd7 && rx_d[7:2] == JSTK_CMD_PREFIX) begin
                led_cmd_q   <= rx_d[1:0];
                cmd_valid_q <= 1'b1;
              end
            end
            if (sclk_fall) begin
              tx_q   <= {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
              miso_q <= tx_q[JSTK_FRAME_BITS-2];
            end
          end
        end
        ST_DONE: begin
          miso_q <= 1'b0;
          if (ss_rise) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          miso_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MISO       = miso_q;
  assign led_cmd    = led_cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_jstk_responder.sv
// Directed bench: a behavioural SPI mode-0 master polls the responder at clk/100 and checks returned bytes and pulses.
module tb_jstk_responder;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       SS = 1'b1;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic [9:0] x_pos = 10'h000;
  logic [9:0] y_pos = 10'h000;
  logic [2:0] buttons = 3'b000;
  logic       MISO;
  logic [1:0] led_cmd;
  logic       cmd_valid;
  logic       frame_done;
  logic       busy;

  int     checks = 0;
  int     errs = 0;
  longint cyc = 0;
  int     cmd_cnt = 0;
  int     done_cnt = 0;
  longint cmd_cyc = 0;

  jstk_responder #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
    .clk(clk), .rst(rst), .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .x_pos(x_pos), .y_pos(y_pos), .buttons(buttons),
    .led_cmd(led_cmd), .cmd_valid(cmd_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid) begin
      cmd_cnt = cmd_cnt + 1;
      cmd_cyc = cyc;
    end
    if (frame_done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [39:0] mo, input int nbits,
                           output logic [39:0] mi, output longint t0, output logic busy_mid);
    logic [39:0] sh;
    sh = mo;
    mi = '0;
    busy_mid = 1'b0;
    @(negedge clk);
    SS = 1'b0;
    MOSI = sh[39];
    t0 = cyc;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b1;
      mi = {mi[38:0], MISO};
      if (i == 0) busy_mid = busy;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      sh = {sh[38:0], 1'b0};
      MOSI = sh[39];
      repeat (HALF) @(negedge clk);
    end
    SS = 1'b1;
    MOSI = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    logic [39:0] mi;
    longint      t0;
    logic        bm;
    int          c0, d0;
    longint      delta;

    repeat (3) @(negedge clk);
    check("rst_miso", 40'(MISO), 40'd0);
    check("rst_led", 40'(led_cmd), 40'd0);
    check("rst_cmd_valid", 40'(cmd_valid), 40'd0);
    check("rst_frame_done", 40'(frame_done), 40'd0);
    check("rst_busy", 40'(busy), 40'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Frame readback
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    d0 = done_cnt;
    spi_frame(40'h0, 40, mi, t0, bm);
    check("rd_busy_mid", 40'(bm), 40'd1);
    check("rd_byte0", 40'(mi[39:32]), 40'hA5);
    check("rd_byte1", 40'(mi[31:24]), 40'h02);
    check("rd_byte2", 40'(mi[23:16]), 40'h3C);
    check("rd_byte3", 40'(mi[15:8]), 40'h01);
    check("rd_byte4", 40'(mi[7:0]), 40'h05);
    check("rd_frame_done_cnt", 40'(done_cnt - d0), 40'd1);
    check("rd_busy_after", 40'(busy), 40'd0);
    check("rd_miso_after", 40'(MISO), 40'd0);

    // LED command accepted
    c0 = cmd_cnt;
    spi_frame({8'b1000_0011, 32'h0}, 40, mi, t0, bm);
    delta = cmd_cyc - t0;
    check("led_value", 40'(led_cmd), 40'd3);
    check("led_pulse_cnt", 40'(cmd_cnt - c0), 40'd1);
    check("led_pulse_timing", 40'(delta >= 745 && delta <= 760), 40'd1);

    // Non-command first bytes leave led_cmd alone
    c0 = cmd_cnt;
    spi_frame(40'h0, 40, mi, t0, bm);
    check("led_zero_hold", 40'(led_cmd), 40'd3);
    check("led_zero_nopulse", 40'(cmd_cnt - c0), 40'd0);
    c0 = cmd_cnt;
    spi_frame({8'b1000_0100, 32'h0}, 40, mi, t0, bm);
    check("led_nearmiss_hold", 40'(led_cmd), 40'd3);
    check("led_nearmiss_nopulse", 40'(cmd_cnt - c0), 40'd0);

    // Abort after 17 bits
    d0 = done_cnt;
    spi_frame(40'h0, 17, mi, t0, bm);
    check("abort_no_done", 40'(done_cnt - d0), 40'd0);
    check("abort_busy", 40'(busy), 40'd0);
    check("abort_miso", 40'(MISO), 40'd0);
    x_pos = 10'h155; y_pos = 10'h2AA; buttons = 3'b010;
    spi_frame(40'h0, 40, mi, t0, bm);
    check("after_abort_frame", mi, 40'h5501AA0202);

    // Snapshot: mid-frame X change applies only to the next frame
    x_pos = 10'h000; y_pos = 10'h000; buttons = 3'b000;
    fork
      spi_frame(40'h0, 40, mi, t0, bm);
      begin
        repeat (1000) @(negedge clk);
        x_pos = 10'h3FF;
      end
    join
    check("snap_cur_x", 40'(mi[39:24]), 40'h0000);
    spi_frame(40'h0, 40, mi, t0, bm);
    check("snap_next_x", 40'(mi[39:24]), 40'hFF03);

    // Async reset mid-frame
    x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
    d0 = done_cnt;
    fork
      spi_frame(40'h0, 40, mi, t0, bm);
      begin
        repeat (HALF + 2 * HALF * 20) @(negedge clk);
        check("prerst_busy", 40'(busy), 40'd1);
        rst = 1'b0;
        #1;
        check("midrst_miso", 40'(MISO), 40'd0);
        check("midrst_led", 40'(led_cmd), 40'd0);
        check("midrst_cmd_valid", 40'(cmd_valid), 40'd0);
        check("midrst_frame_done", 40'(frame_done), 40'd0);
        check("midrst_busy", 40'(busy), 40'd0);
        @(negedge clk);
        rst = 1'b1;
      end
    join
    check("postrst_no_done", 40'(done_cnt - d0), 40'd0);
    check("postrst_busy", 40'(busy), 40'd0);
    spi_frame(40'h0, 40, mi, t0, bm);
    check("postrst_frame", mi, 40'hA5023C0105);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
